sim_periph_shim: RTL and testbench
==================================

# sim_periph_shim

Parametrised simulation-side peripheral model for the raster kernel under Verilator. It emulates N SPI DAC channels with register read/write semantics. It also delays per-channel ADC arm and RAM write strobes by amounts programmable at run time. It sits between the raster core plus RAM shim and the C++ testbench, and generalises the fixed two-axis, fixed-delay simulation wrapper. New behaviour over that wrapper: per-channel ADC delay counters, arm de-assertion, run-time wait programming, and abortable DAC transactions.

## Interface
- DAC_NUM, 2, number of emulated DAC channels
- DAC_DATA_WID, 20, DAC value register width
- DAC_WID, 24, DAC SPI word width (4-bit opcode + payload); DAC_WID >= DAC_DATA_WID+4
- ADCNUM, 9, number of ADC arm channels
- WAIT_WID, 16, width of wait registers and counters
- DAC_WAIT_DEFAULT, 0, reset value of DAC wait
- ADC_WAIT_DEFAULT, 54, reset value of ADC wait
- RAM_WAIT_DEFAULT, 54, reset value of RAM wait

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_sel  in  2  wait register select: 0 DAC, 1 ADC, 2 RAM, 3 reserved
- cfg_data  in  WAIT_WID  wait value
- cfg_write  in  1  write strobe, one-cycle sample
- dac_arm  in  DAC_NUM  per-channel transaction request, level
- dac_cmd  in  DAC_NUM*DAC_WID  packed words from master; channel i at [(i+1)*DAC_WID-1 : i*DAC_WID]
- dac_resp  out  DAC_NUM*DAC_WID  packed words returned to master
- dac_finished  out  DAC_NUM  per-channel transaction done
- dac_value  out  DAC_NUM*DAC_DATA_WID  packed DAC output registers
- adc_arm_in  in  ADCNUM  arm requests from core
- adc_arm_out  out  ADCNUM  delayed arms to testbench
- ram_write_in  in  1  write request from RAM shim
- ram_write_out  out  1  delayed write to testbench

## Operation
- Reset: dac_resp, dac_finished, dac_value, per-channel write_buf, adc_arm_out and ram_write_out all clear to 0. Counters clear to 0. Wait registers load their defaults. All DAC FSMs enter IDLE.
- Config: on a cfg_write edge, the register selected by cfg_sel loads cfg_data. cfg_sel=3 is ignored. Counters compare against the live wait value, so a mid-count change takes effect immediately.
- DAC channel FSM (independent per channel): IDLE, WAIT, DONE.
  - IDLE with arm=1 latches cmd. If dac_wait=0, the channel completes on the same edge; otherwise cnt<=1 and the FSM enters WAIT.
  - WAIT with arm=0 aborts to IDLE, with no register effect and finished kept at 0.
  - WAIT with cnt==dac_wait completes. Otherwise cnt++.
  - Complete:
    - resp<=write_buf; finished<=1; go to DONE.
    - Decode latched cmd[DAC_WID-1:DAC_WID-4].
    - 4'b1001 (readback): write_buf<={4'b1001, zero-pad, value}.
    - 4'b0001 (write): value<=cmd[DAC_DATA_WID-1:0] and write_buf<=0.
    - Any other opcode: no effect on value or write_buf.
  - DONE holds finished=1 until arm=0, then finished<=0 and the FSM returns to IDLE.
  - Readback is full-duplex: the value appears in resp on the transaction after the 1001 command.
- ADC channel i: if adc_arm_in[i]=0 then cnt<=0 and out<=0. Else if cnt<adc_wait then cnt++. Else out<=1.
- RAM: identical rule on ram_write_in/ram_write_out with ram_wait.
- Counters never exceed the wait value, so there is no overflow. Maximum delay is 2^WAIT_WID-1.

## Timing
- Let k be the first edge sampling a request high. Every output rises after edge k+W, where W is the wait in effect; W=0 gives one-cycle registered latency.
- ADC/RAM outputs fall on the first edge sampling the input low; this is an abort if the input drops before completion.
- dac_finished falls on the first edge sampling dac_arm low in DONE.
- Re-arm in the same cycle finished falls is not sampled until IDLE, so a minimum 1-cycle gap is inherent.
- If a wait is lowered below the current cnt, the channel completes on the next edge.
- Asynchronous rst mid-transaction forces all outputs to 0 immediately. dac_value is lost and the waits return to defaults.
- Channels are fully concurrent; simultaneous arms on all channels complete on the same edge when the waits are equal.

## Test plan
- DAC write/readback, channel 1, dac_wait=0:
  - Arm cmd 0x1ABCDE -> finished after 1 edge; dac_value[1]=0xABCDE.
  - Arm 0x900000, then arm 0x000000 -> second resp=0x9ABCDE; channel 0 value stays 0.
- DAC wait=5:
  - Arm held -> finished exactly 5 edges after first sample.
  - Drop arm at edge 3 -> finished never rises and value is unchanged.
- ADC default wait 54:
  - adc_arm_in=9'h1FF -> adc_arm_out=9'h1FF after edge k+54.
  - Drop bit 3 -> bit 3 clears next edge while the other bits stay high.
- Staggered ADC: bit 0 armed at k, bit 1 at k+10 with wait 20 -> outputs rise at k+20 and k+30 respectively.
- RAM config: cfg_sel=2, cfg_data=3 written, then ram_write_in high -> ram_write_out high after edge k+3. Lower the wait to 1 while cnt=2 -> out rises next edge.
- Reset mid-operation: rst asserted during a DAC WAIT and an ADC count -> all outputs 0 without a clock; after release, waits read back defaults (ADC latency 54 again).

Source files
------------

// File: rtl/sim_periph_shim_if.sv
// Bus between the raster core / RAM shim (master) and the simulation peripheral shim (slave).
interface sim_periph_shim_if #(
    parameter int DAC_NUM      = 2,
    parameter int DAC_DATA_WID = 20,
    parameter int DAC_WID      = 24,
    parameter int ADCNUM       = 9,
    parameter int WAIT_WID     = 16
);
    logic [1:0]                      cfg_sel;
    logic [WAIT_WID-1:0]             cfg_data;
    logic                            cfg_write;
    logic [DAC_NUM-1:0]              dac_arm;
    logic [DAC_NUM*DAC_WID-1:0]      dac_cmd;
    logic [DAC_NUM*DAC_WID-1:0]      dac_resp;
    logic [DAC_NUM-1:0]              dac_finished;
    logic [DAC_NUM*DAC_DATA_WID-1:0] dac_value;
    logic [ADCNUM-1:0]               adc_arm_in;
    logic [ADCNUM-1:0]               adc_arm_out;
    logic                            ram_write_in;
    logic                            ram_write_out;

    modport master (
        output cfg_sel, cfg_data, cfg_write, dac_arm, dac_cmd, adc_arm_in, ram_write_in,
        input  dac_resp, dac_finished, dac_value, adc_arm_out, ram_write_out
    );

    modport slave (
        input  cfg_sel, cfg_data, cfg_write, dac_arm, dac_cmd, adc_arm_in, ram_write_in,
        output dac_resp, dac_finished, dac_value, adc_arm_out, ram_write_out
    );
endinterface

// File: rtl/sim_periph_shim.sv
// Emulated SPI DAC channels plus run-time programmable delays on ADC arms and RAM write strobe.
// Outputs are registered: a request first sampled at edge k shows up after edge k+W; dropping a request aborts.
module sim_periph_shim #(
    parameter int DAC_NUM          = 2,
    parameter int DAC_DATA_WID     = 20,
    parameter int DAC_WID          = 24,
    parameter int ADCNUM           = 9,
    parameter int WAIT_WID         = 16,
    parameter int DAC_WAIT_DEFAULT = 0,
    parameter int ADC_WAIT_DEFAULT = 54,
    parameter int RAM_WAIT_DEFAULT = 54
) (
    input  logic               clk,
    input  logic               rst,
    sim_periph_shim_if.slave   bus
);
    localparam logic [3:0] OP_READ  = 4'b1001;
    localparam logic [3:0] OP_WRITE = 4'b0001;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} dac_state_e;

    logic [WAIT_WID-1:0] dac_wait_q, adc_wait_q, ram_wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_wait_q <= WAIT_WID'(DAC_WAIT_DEFAULT);
            adc_wait_q <= WAIT_WID'(ADC_WAIT_DEFAULT);
            ram_wait_q <= WAIT_WID'(RAM_WAIT_DEFAULT);
        end else if (bus.cfg_write) begin
            case (bus.cfg_sel)
                2'd0:    dac_wait_q <= bus.cfg_data;
                2'd1:    adc_wait_q <= bus.cfg_data;
                2'd2:    ram_wait_q <= bus.cfg_data;
                default: ;
            endcase
        end
    end

    logic [DAC_NUM-1:0][DAC_WID-1:0]      resp_all;
    logic [DAC_NUM-1:0][DAC_DATA_WID-1:0] value_all;
    logic [DAC_NUM-1:0]                   fin_all;

    for (genvar i = 0; i < DAC_NUM; i++) begin : g_dac
        dac_state_e              state_q;
        logic [WAIT_WID-1:0]     cnt_q;
        logic [3:0]              op_q;
        logic [DAC_DATA_WID-1:0] data_q;
        logic [DAC_WID-1:0]      buf_q;
        logic [DAC_WID-1:0]      resp_q;
        logic [DAC_DATA_WID-1:0] value_q;
        logic                    fin_q;

        logic                    arm;
        logic [3:0]              op_in, op_eff;
        logic [DAC_DATA_WID-1:0] data_in, data_eff;
        logic                    complete;
        logic [DAC_WID-1:0]      readback;

        assign arm     = bus.dac_arm[i];
        assign op_in   = bus.dac_cmd[(i+1)*DAC_WID-1 -: 4];
        assign data_in = bus.dac_cmd[i*DAC_WID +: DAC_DATA_WID];
        // A zero-wait transaction completes on the arming edge, so decode the live command there.
        assign op_eff   = (state_q == ST_IDLE) ? op_in : op_q;
        assign data_eff = (state_q == ST_IDLE) ? data_in : data_q;
        assign complete = arm && (((state_q == ST_IDLE) && (dac_wait_q == '0)) ||
                                  ((state_q == ST_WAIT) && (cnt_q >= dac_wait_q)));
        assign readback = (DAC_WID'(OP_READ) << (DAC_WID - 4)) | DAC_WID'(value_q);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                op_q    <= '0;
                data_q  <= '0;
                buf_q   <= '0;
                resp_q  <= '0;
                value_q <= '0;
                fin_q   <= 1'b0;
            end else begin
                if ((state_q == ST_IDLE) && arm) begin
                    op_q   <= op_in;
                    data_q <= data_in;
                end
                if (complete) begin
                    resp_q  <= buf_q;
                    fin_q   <= 1'b1;
                    state_q <= ST_DONE;
                    if (op_eff == OP_READ) begin
                        buf_q <= readback;
                    end else if (op_eff == OP_WRITE) begin
                        value_q <= data_eff;
                        buf_q   <= '0;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: if (arm) begin
                            cnt_q   <= WAIT_WID'(1);
                            state_q <= ST_WAIT;
                        end
                        ST_WAIT: if (!arm) state_q <= ST_IDLE;
                                 else      cnt_q   <= cnt_q + WAIT_WID'(1);
                        ST_DONE: if (!arm) begin
                            fin_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end

        assign resp_all[i]  = resp_q;
        assign value_all[i] = value_q;
        assign fin_all[i]   = fin_q;
    end

    assign bus.dac_resp     = resp_all;
    assign bus.dac_value    = value_all;
    assign bus.dac_finished = fin_all;

    logic [WAIT_WID-1:0] adc_cnt_q [ADCNUM];
    logic [ADCNUM-1:0]   adc_out_q;
    logic [WAIT_WID-1:0] ram_cnt_q;
    logic                ram_out_q;

    // Counters stop at the live wait value, so lowering the wait fires on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < ADCNUM; j++) adc_cnt_q[j] <= '0;
            adc_out_q <= '0;
            ram_cnt_q <= '0;
            ram_out_q <= 1'b0;
        end else begin
            for (int j = 0; j < ADCNUM; j++) begin
                if (!bus.adc_arm_in[j]) begin
                    adc_cnt_q[j] <= '0;
                    adc_out_q[j] <= 1'b0;
                end else if (adc_cnt_q[j] < adc_wait_q) begin
                    adc_cnt_q[j] <= adc_cnt_q[j] + WAIT_WID'(1);
                end else begin
                    adc_out_q[j] <= 1'b1;
                end
            end
            if (!bus.ram_write_in) begin
                ram_cnt_q <= '0;
                ram_out_q <= 1'b0;
            end else if (ram_cnt_q < ram_wait_q) begin
                ram_cnt_q <= ram_cnt_q + WAIT_WID'(1);
            end else begin
                ram_out_q <= 1'b1;
            end
        end
    end

    assign bus.adc_arm_out   = adc_out_q;
    assign bus.ram_write_out = ram_out_q;
endmodule

// File: tb/tb_sim_periph_shim.sv
// Bench for sim_periph_shim: DAC vector table, directed timing sequences, randomized runs vs. a run-length model.
module tb_sim_periph_shim;
    localparam int DN  = 2;
    localparam int DDW = 20;
    localparam int DW  = 24;
    localparam int AN  = 9;
    localparam int WW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sim_periph_shim_if #(.DAC_NUM(DN), .DAC_DATA_WID(DDW), .DAC_WID(DW), .ADCNUM(AN), .WAIT_WID(WW)) bus();

    sim_periph_shim #(
        .DAC_NUM(DN), .DAC_DATA_WID(DDW), .DAC_WID(DW), .ADCNUM(AN), .WAIT_WID(WW),
        .DAC_WAIT_DEFAULT(0), .ADC_WAIT_DEFAULT(54), .RAM_WAIT_DEFAULT(54)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0]  cmd;
        logic [DW-1:0]  exp_resp;
        logic [DDW-1:0] exp_val;
    } dac_vec_t;

    dac_vec_t vt [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [WW-1:0] d);
        bus.cfg_sel   = sel;
        bus.cfg_data  = d;
        bus.cfg_write = 1'b1;
        tick();
        bus.cfg_write = 1'b0;
    endtask

    function automatic logic [DDW-1:0] dval(input int ch);
        return bus.dac_value[ch*DDW +: DDW];
    endfunction

    // Arms channel ch, counts edges until finished (bounded), captures resp, then drops arm for one edge.
    task automatic dac_txn(input int ch, input logic [DW-1:0] cmd, input int w,
                           output int lat, output logic [DW-1:0] resp);
        bus.dac_cmd[ch*DW +: DW] = cmd;
        bus.dac_arm[ch] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.dac_finished[ch] && lat < w + 20);
        resp = bus.dac_resp[ch*DW +: DW];
        bus.dac_arm[ch] = 1'b0;
        tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int              lat;
        logic [DW-1:0]   resp;
        logic [AN-1:0]   exp_adc;
        int              run [AN];
        int              ram_run;
        int              wa, wr, wd, ch, sel;
        logic [DW-1:0]   cmd;
        logic [DDW-1:0]  mval [DN];
        logic [DW-1:0]   mbuf [DN];
        logic [DW-1:0]   exp_resp;

        vt[0] = '{24'h1ABCDE, 24'h000000, 20'hABCDE};
        vt[1] = '{24'h900000, 24'h000000, 20'hABCDE};
        vt[2] = '{24'h000000, 24'h9ABCDE, 20'hABCDE};
        vt[3] = '{24'h112345, 24'h9ABCDE, 20'h12345};
        vt[4] = '{24'h900000, 24'h000000, 20'h12345};
        vt[5] = '{24'h5FFFFF, 24'h912345, 20'h12345};

        rst = 1'b1;
        bus.cfg_sel = '0; bus.cfg_data = '0; bus.cfg_write = 1'b0;
        bus.dac_arm = '0; bus.dac_cmd = '0;
        bus.adc_arm_in = '0; bus.ram_write_in = 1'b0;
        #12;
        check("reset_resp",     bus.dac_resp, 0);
        check("reset_finished", bus.dac_finished, 0);
        check("reset_value",    bus.dac_value, 0);
        check("reset_adc",      bus.adc_arm_out, 0);
        check("reset_ram",      bus.ram_write_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // DAC table on channel 1 with default wait 0
        for (int i = 0; i < 6; i++) begin
            dac_txn(1, vt[i].cmd, 0, lat, resp);
            check($sformatf("tbl%0d_latency", i), lat, 1);
            check($sformatf("tbl%0d_resp", i), resp, vt[i].exp_resp);
            check($sformatf("tbl%0d_value", i), dval(1), vt[i].exp_val);
            check($sformatf("tbl%0d_fin_low", i), bus.dac_finished[1], 0);
        end
        check("ch0_value_untouched", dval(0), 0);

        // DAC wait 5: latency and abort
        cfg(2'd0, 16'd5);
        dac_txn(0, 24'h100055, 5, lat, resp);
        check("wait5_latency", lat, 6);
        check("wait5_value", dval(0), 20'h00055);
        bus.dac_cmd[0 +: DW] = 24'h177777;
        bus.dac_arm[0] = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        check("abort_pre_fin", bus.dac_finished[0], 0);
        bus.dac_arm[0] = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        check("abort_fin", bus.dac_finished[0], 0);
        check("abort_value", dval(0), 20'h00055);
        cfg(2'd0, 16'd0);

        // ADC default wait 54
        bus.adc_arm_in = 9'h1FF;
        for (int t = 0; t < 54; t++) tick();
        check("adc54_before", bus.adc_arm_out, 9'h000);
        tick();
        check("adc54_rise", bus.adc_arm_out, 9'h1FF);
        bus.adc_arm_in = 9'h1F7;
        tick();
        check("adc_drop_bit3", bus.adc_arm_out, 9'h1F7);
        bus.adc_arm_in = '0;
        tick();
        check("adc_all_low", bus.adc_arm_out, 9'h000);

        // Staggered arms with wait 20
        cfg(2'd1, 16'd20);
        for (int t = 0; t < 40; t++) begin
            if (t == 0)  bus.adc_arm_in[0] = 1'b1;
            if (t == 10) bus.adc_arm_in[1] = 1'b1;
            tick();
            check($sformatf("stagger_t%0d", t), bus.adc_arm_out[1:0], {t >= 30, t >= 20});
        end
        bus.adc_arm_in = '0;
        tick();

        // RAM wait 3, then lowering mid-count
        cfg(2'd2, 16'd3);
        bus.ram_write_in = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        check("ram3_before", bus.ram_write_out, 0);
        tick();
        check("ram3_rise", bus.ram_write_out, 1);
        bus.ram_write_in = 1'b0;
        tick();
        check("ram3_fall", bus.ram_write_out, 0);
        cfg(2'd2, 16'd5);
        bus.ram_write_in = 1'b1;
        tick();
        tick();
        cfg(2'd2, 16'd1);
        check("ram_lower_before", bus.ram_write_out, 0);
        tick();
        check("ram_lower_rise", bus.ram_write_out, 1);

        // Asynchronous reset mid-operation
        cfg(2'd0, 16'd4);
        bus.dac_cmd[0 +: DW] = 24'h10000A;
        bus.dac_arm[0] = 1'b1;
        bus.adc_arm_in = 9'h1FF;
        for (int t = 0; t < 3; t++) tick();
        check("pre_rst_ram", bus.ram_write_out, 1);
        check("pre_rst_value1", dval(1), 20'h12345);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_resp", bus.dac_resp, 0);
        check("rst_async_fin", bus.dac_finished, 0);
        check("rst_async_value", bus.dac_value, 0);
        check("rst_async_adc", bus.adc_arm_out, 0);
        check("rst_async_ram", bus.ram_write_out, 0);
        bus.dac_arm = '0;
        bus.adc_arm_in = '0;
        bus.ram_write_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.adc_arm_in = 9'h1FF;
        bus.ram_write_in = 1'b1;
        for (int t = 0; t < 54; t++) tick();
        check("post_rst_adc_before", bus.adc_arm_out, 9'h000);
        check("post_rst_ram_before", bus.ram_write_out, 0);
        tick();
        check("post_rst_adc_rise", bus.adc_arm_out, 9'h1FF);
        check("post_rst_ram_rise", bus.ram_write_out, 1);
        bus.adc_arm_in = '0;
        bus.ram_write_in = 1'b0;
        tick();
        dac_txn(0, 24'h000000, 0, lat, resp);
        check("post_rst_dac_latency", lat, 1);
        check("post_rst_dac_resp", resp, 0);

        // Randomized ADC/RAM against a run-length model
        wa = $urandom_range(0, 6);
        wr = $urandom_range(0, 6);
        cfg(2'd1, WW'(wa));
        cfg(2'd2, WW'(wr));
        for (int j = 0; j < AN; j++) run[j] = 0;
        ram_run = 0;
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < AN; j++)
                if ($urandom_range(0, 3) == 0) bus.adc_arm_in[j] = ~bus.adc_arm_in[j];
            if ($urandom_range(0, 3) == 0) bus.ram_write_in = ~bus.ram_write_in;
            tick();
            for (int j = 0; j < AN; j++) begin
                run[j] = bus.adc_arm_in[j] ? run[j] + 1 : 0;
                exp_adc[j] = (run[j] >= wa + 1);
            end
            ram_run = bus.ram_write_in ? ram_run + 1 : 0;
            check($sformatf("rnd_adc_c%0d", c), bus.adc_arm_out, exp_adc);
            check($sformatf("rnd_ram_c%0d", c), bus.ram_write_out, ram_run >= wr + 1);
        end
        bus.adc_arm_in = '0;
        bus.ram_write_in = 1'b0;
        tick();

        // Randomized DAC transactions against a register-level model
        for (int k = 0; k < DN; k++) begin
            mval[k] = '0;
            mbuf[k] = '0;
        end
        for (int n = 0; n < 30; n++) begin
            ch  = $urandom_range(0, DN - 1);
            wd  = $urandom_range(0, 3);
            sel = $urandom_range(0, 2);
            cmd = DW'($urandom);
            if (sel == 0)      cmd[DW-1 -: 4] = 4'b0001;
            else if (sel == 1) cmd[DW-1 -: 4] = 4'b1001;
            else if (cmd[DW-1 -: 4] == 4'b0001 || cmd[DW-1 -: 4] == 4'b1001) cmd[DW-1 -: 4] = 4'b0110;
            cfg(2'd0, WW'(wd));
            exp_resp = mbuf[ch];
            if (sel == 0) begin
                mval[ch] = cmd[DDW-1:0];
                mbuf[ch] = '0;
            end else if (sel == 1) begin
                mbuf[ch] = (DW'(4'b1001) << (DW - 4)) | DW'(mval[ch]);
            end
            dac_txn(ch, cmd, wd, lat, resp);
            check($sformatf("rnd_dac%0d_latency", n), lat, wd + 1);
            check($sformatf("rnd_dac%0d_resp", n), resp, exp_resp);
            check($sformatf("rnd_dac%0d_val0", n), dval(0), mval[0]);
            check($sformatf("rnd_dac%0d_val1", n), dval(1), mval[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
